v2f_iter_div: RTL and testbench
===============================

V2F_ITER_DIV -- requirements
Module: v2f_iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; legal range 33..64 (covers $div/$mod cells wider than 32 bits).
REQ-002 SHALL have parameter SIGNED, default 0; 1 selects two's-complement operands and results.
REQ-003 SHALL have port CLK  input  1  single clock, rising edge.
REQ-004 SHALL have port ARST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port START  input  1  request; sampled on rising CLK.
REQ-006 SHALL have port A  input  WIDTH  dividend.
REQ-007 SHALL have port B  input  WIDTH  divisor.
REQ-008 SHALL have port BUSY  output  1  high while a division is in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse marking Y valid.
REQ-010 SHALL have port Y  output  WIDTH  quotient, held until the next accepted START.
REQ-011 SHALL have port DIV0  output  1  high with DONE when B was zero; held with Y.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX.
REQ-013 SHALL accept START only in IDLE; an accepting edge (e0) captures A and B, clears DONE, sets BUSY and enters CALC.
REQ-014 SHALL ignore START while BUSY; captured operands SHALL NOT change.
REQ-015 SHALL perform one restoring shift-subtract iteration per CALC edge, WIDTH iterations (e1..eWIDTH), then enter FIX.
REQ-016 SHALL, at FIX edge e(WIDTH+1), apply sign correction, load Y, pulse DONE for one cycle, clear BUSY and return to IDLE; latency WIDTH+1 edges after e0.
REQ-017 SHALL, for SIGNED=1, divide magnitudes and truncate toward zero; quotient negative iff operand signs differ.
REQ-018 SHALL, for SIGNED=1 and A = most-negative and B = -1, produce Y = most-negative (wrap), DIV0=0.
REQ-019 SHALL, when B = 0 at e0, skip CALC: at e1 drive Y=0, DIV0=1, DONE=1, BUSY=0 (Factorio combinator semantics).
REQ-020 SHALL accept START asserted during the DONE cycle (state IDLE) as a new request.
REQ-021 SHALL treat all operands as unsigned when SIGNED=0; A < B gives Y=0.

Reset
REQ-022 SHALL, on ARST high, immediately force state IDLE, BUSY=0, DONE=0, DIV0=0, Y=0, R=0 (when present), internal counter 0, regardless of clock.
REQ-023 SHALL abandon any in-flight division on ARST; no DONE pulse follows release.
REQ-024 SHALL accept START on the first rising CLK after ARST deasserts.

Configuration
REQ-025 SHALL use macro V2F_ITER_DIV_REM_EN to include a remainder output.
REQ-026 SHALL, with V2F_ITER_DIV_REM_EN defined, add port R  output  WIDTH  remainder, loaded with Y, sign following the dividend (SIGNED=1), R=0 on divide-by-zero and on the REQ-018 overflow case.
REQ-027 SHALL, without V2F_ITER_DIV_REM_EN, omit port R and its correction logic; all other behaviour and timing unchanged.

Verification (bench WIDTH=33 unless noted)
REQ-028 SHALL cover unsigned: START, A=100, B=7 -> DONE after exactly 34 edges, Y=14, R=2, DIV0=0, BUSY low same cycle.
REQ-029 SHALL cover signed (SIGNED=1): A=-100, B=7 -> Y=-14, R=-2; A=100, B=-7 -> Y=-14, R=2.
REQ-030 SHALL cover divide-by-zero: A=55, B=0 -> DONE at e1, Y=0, R=0, DIV0=1.
REQ-031 SHALL cover overflow (SIGNED=1): A=-2^32, B=-1 -> Y=-2^32, R=0, DIV0=0.
REQ-032 SHALL cover busy/back-to-back: START with new A/B mid-CALC ignored, result matches first operands; START in DONE cycle (A=9, B=3) -> Y=3 after a further 34 edges.
REQ-033 SHALL cover reset mid-operation: ARST asserted at iteration 10 -> outputs zero asynchronously, no DONE afterward, next START (A=8, B=2) -> Y=4.

Source files
------------

// File: rtl/v2f_iter_div.sv
// v2f_iter_div: multi-cycle restoring divider with optional signed mode.
// Accepts a request in IDLE, runs WIDTH shift-subtract iterations in CALC,
// then applies sign correction and publishes the quotient in FIX.
// A zero divisor bypasses CALC and reports DIV0 with a zero quotient.
// Optional feature: define V2F_ITER_DIV_REM_EN to add the remainder port R.
module v2f_iter_div #(
  parameter int WIDTH  = 64,
  parameter bit SIGNED = 1'b0
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             DIV0
`ifdef V2F_ITER_DIV_REM_EN
  ,
  output logic [WIDTH-1:0] R
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvs;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               a_neg;
  logic               b_neg;
  logic signed [WIDTH:0] shifted;
  logic signed [WIDTH:0] trial;
  logic               fits;

  // Two's-complement negate when requested; the most-negative value maps to
  // itself, which is exactly the wrap behaviour wanted for overflow.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign a_neg = SIGNED && A[WIDTH-1];
  assign b_neg = SIGNED && B[WIDTH-1];
  assign BUSY  = (state != IDLE);

  // One restoring step: shift in the next dividend bit, trial-subtract divisor.
  // The partial remainder is always below the divisor, so a set MSB on the
  // trial difference means the subtraction borrowed.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - $signed({1'b0, dvs});
    fits    = ~trial[WIDTH];
  end

  // State register.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: zero divisor skips straight to FIX; CALC runs WIDTH edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) state_nxt = (B == '0) ? FIX : CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result/flag registers.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      DONE  <= 1'b0;
      DIV0  <= 1'b0;
      Y     <= '0;
`ifdef V2F_ITER_DIV_REM_EN
      R     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            quo   <= cond_neg(A, a_neg);
            dvs   <= cond_neg(B, b_neg);
            rem   <= '0;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= (B == '0);
          end
        end
        CALC: begin
          quo <= {quo[WIDTH-2:0], fits};
          rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          DONE <= 1'b1;
          DIV0 <= dz;
          Y    <= dz ? '0 : cond_neg(quo, neg_q);
`ifdef V2F_ITER_DIV_REM_EN
          R    <= dz ? '0 : cond_neg(rem, neg_r);
`endif
        end
        default: DONE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_v2f_iter_div.sv
// Bench for v2f_iter_div: one unsigned and one signed instance (WIDTH=33)
// share the stimulus; a latency/arithmetic model predicts every output.
module tb_v2f_iter_div;

  localparam int W = 33;

  logic         CLK = 1'b0;
  logic         ARST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [1:0]   busy_w;
  logic [1:0]   done_w;
  logic [1:0]   div0_w;
  logic [W-1:0] y_w [2];
`ifdef V2F_ITER_DIV_REM_EN
  logic [W-1:0] r_w [2];
`endif

  int total = 0;
  int bad   = 0;
  int n;

  always #5 CLK = ~CLK;

  v2f_iter_div #(.WIDTH(W), .SIGNED(1'b0)) u_uns (
    .CLK(CLK), .ARST(ARST), .START(START), .A(A), .B(B),
    .BUSY(busy_w[0]), .DONE(done_w[0]), .Y(y_w[0]), .DIV0(div0_w[0])
`ifdef V2F_ITER_DIV_REM_EN
    , .R(r_w[0])
`endif
  );

  v2f_iter_div #(.WIDTH(W), .SIGNED(1'b1)) u_sgn (
    .CLK(CLK), .ARST(ARST), .START(START), .A(A), .B(B),
    .BUSY(busy_w[1]), .DONE(done_w[1]), .Y(y_w[1]), .DIV0(div0_w[1])
`ifdef V2F_ITER_DIV_REM_EN
    , .R(r_w[1])
`endif
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain 64-bit division of the operands.
  task automatic ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] y, output logic [W-1:0] r, output bit d);
    longint sa, sb, q, m;
    if (b == '0) begin
      y = '0; r = '0; d = 1'b1;
    end else begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = longint'({31'b0, a});
        sb = longint'({31'b0, b});
      end
      q = sa / sb;
      m = sa % sb;
      y = q[W-1:0];
      r = m[W-1:0];
      d = 1'b0;
    end
  endtask

  // Behavioural model: an accepted request completes W+1 edges later
  // (one edge for a zero divisor); results are held until replaced.
  bit           m_busy [2];
  int           m_left [2];
  bit           m_done [2];
  bit           m_div0 [2];
  logic [W-1:0] m_y [2];
  logic [W-1:0] m_r [2];
  logic [W-1:0] p_y [2];
  logic [W-1:0] p_r [2];
  bit           p_div0 [2];

  always @(posedge CLK or posedge ARST) begin
    for (int k = 0; k < 2; k++) begin
      if (ARST) begin
        m_busy[k] = 1'b0; m_left[k] = 0; m_done[k] = 1'b0;
        m_div0[k] = 1'b0; m_y[k] = '0; m_r[k] = '0;
      end else if (!m_busy[k] && START) begin
        ref_div(k == 1, A, B, p_y[k], p_r[k], p_div0[k]);
        m_busy[k] = 1'b1;
        m_left[k] = (B == '0) ? 1 : W + 1;
        m_done[k] = 1'b0;
      end else if (m_busy[k]) begin
        m_left[k]--;
        m_done[k] = 1'b0;
        if (m_left[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
          m_y[k]    = p_y[k];
          m_r[k]    = p_r[k];
          m_div0[k] = p_div0[k];
        end
      end else begin
        m_done[k] = 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      chk(k ? "sgn.busy" : "uns.busy", W'(busy_w[k]), W'(m_busy[k]));
      chk(k ? "sgn.done" : "uns.done", W'(done_w[k]), W'(m_done[k]));
      chk(k ? "sgn.div0" : "uns.div0", W'(div0_w[k]), W'(m_div0[k]));
      chk(k ? "sgn.y" : "uns.y", y_w[k], m_y[k]);
`ifdef V2F_ITER_DIV_REM_EN
      chk(k ? "sgn.r" : "uns.r", r_w[k], m_r[k]);
`endif
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 100) begin
      @(posedge CLK);
      cnt++;
      #1;
      if (done_w[0]) break;
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, output int cnt);
    @(negedge CLK);
    launch(a, b);
    wait_done(cnt);
  endtask

  initial begin
    #1 ARST = 1'b1;
    #2;
    chk("rst.busy", W'(busy_w), '0);
    chk("rst.done", W'(done_w), '0);
    chk("rst.y", y_w[0] | y_w[1], '0);
    @(negedge CLK);
    ARST = 1'b0;

    // Unsigned 100/7 on both instances.
    op(33'd100, 33'd7, n);
    chk("lat.100_7", W'(n), W'(34));
    chk("uns.100_7", y_w[0], 33'd14);
    chk("sgn.100_7", y_w[1], 33'd14);
    chk("busy.at_done", W'(busy_w), '0);
    chk("div0.100_7", W'(div0_w), '0);
`ifdef V2F_ITER_DIV_REM_EN
    chk("rem.100_7", r_w[0], 33'd2);
`endif

    // -100 / 7 (signed view), unsigned instance sees a large dividend.
    op(33'h1_FFFF_FF9C, 33'd7, n);
    chk("sgn.m100_7", y_w[1], 33'h1_FFFF_FFF2);
`ifdef V2F_ITER_DIV_REM_EN
    chk("rem.m100_7", r_w[1], 33'h1_FFFF_FFFE);
`endif

    // 100 / -7: signed -14, unsigned A<B gives 0.
    op(33'd100, 33'h1_FFFF_FFF9, n);
    chk("sgn.100_m7", y_w[1], 33'h1_FFFF_FFF2);
    chk("uns.a_lt_b", y_w[0], '0);
`ifdef V2F_ITER_DIV_REM_EN
    chk("rem.100_m7", r_w[1], 33'd2);
`endif

    // Divide by zero completes one edge after acceptance.
    op(33'd55, 33'd0, n);
    chk("lat.div0", W'(n), W'(1));
    chk("y.div0", y_w[0] | y_w[1], '0);
    chk("flag.div0", W'(div0_w), W'(2'b11));

    // Most-negative / -1 wraps.
    op(33'h1_0000_0000, 33'h1_FFFF_FFFF, n);
    chk("sgn.ovf", y_w[1], 33'h1_0000_0000);
    chk("flag.ovf", W'(div0_w[1]), '0);
`ifdef V2F_ITER_DIV_REM_EN
    chk("rem.ovf", r_w[1], '0);
`endif

    // Full-width dividend divided by one.
    op(33'h1_FFFF_FFFF, 33'd1, n);
    chk("uns.max_1", y_w[0], 33'h1_FFFF_FFFF);

    // START with other operands mid-CALC is ignored.
    @(negedge CLK);
    launch(33'd100, 33'd7);
    repeat (10) @(posedge CLK);
    #1 A = 33'd1; B = 33'd1; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done(n);
    chk("lat.ignored", W'(n), W'(23));
    chk("uns.ignored", y_w[0], 33'd14);

    // New request raised during the DONE cycle.
    chk("done.b2b", W'(done_w), W'(2'b11));
    launch(33'd9, 33'd3);
    wait_done(n);
    chk("lat.b2b", W'(n), W'(34));
    chk("uns.9_3", y_w[0], 33'd3);

    // Asynchronous reset at iteration 10 abandons the operation.
    @(negedge CLK);
    launch(33'd1000, 33'd3);
    repeat (10) @(posedge CLK);
    #2 ARST = 1'b1;
    #1;
    chk("arst.busy", W'(busy_w), '0);
    chk("arst.done", W'(done_w), '0);
    chk("arst.y", y_w[0] | y_w[1], '0);
    chk("arst.div0", W'(div0_w), '0);
    @(negedge CLK);
    ARST = 1'b0;
    launch(33'd8, 33'd2);
    wait_done(n);
    chk("lat.after_rst", W'(n), W'(34));
    chk("uns.8_2", y_w[0], 33'd4);
    chk("sgn.8_2", y_w[1], 33'd4);

    repeat (3) @(posedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
